// File: rtl/obstacle_sequencer_pkg.sv
// game_pkg: constants and types shared by the sequencer and the obstacle modules.
//   Obstacle select codes (0 = none), sequencer state encoding,
//   screen/arena geometry and a round-robin code helper.
package game_pkg;

    localparam logic [2:0] NO_OBSTACLE  = 3'd0;
    localparam logic [2:0] LASERS_CODE  = 3'b001;
    localparam logic [2:0] BULLETS_CODE = 3'b010;
    localparam logic [2:0] WALLS_CODE   = 3'b011;
    localparam logic [2:0] SPIKES_CODE  = 3'b100;

    localparam int unsigned SCREEN_W = 1280;
    localparam int unsigned SCREEN_H = 720;
    localparam int unsigned ARENA_X0 = 160;
    localparam int unsigned ARENA_Y0 = 40;
    localparam int unsigned ARENA_X1 = 1120;
    localparam int unsigned ARENA_Y1 = 680;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_NEXT,
        S_OVER
    } seq_state_e;

    // Codes run 1..num and wrap back to 1.
    function automatic logic [2:0] next_code(input logic [2:0] code, input logic [2:0] num);
        return (code == num) ? LASERS_CODE : code + 3'd1;
    endfunction

endpackage

// File: rtl/obstacle_sequencer_hit_detector.sv
// hit_detector: registered player/obstacle pixel overlap flag.
//   clk, rst             : clock, async active-high reset
//   player_x, player_y   : top-left of the square player hitbox
//   obstacle_x, obstacle_y: OR-combined obstacle pixel, (0,0) = no pixel
//   overlap              : registered overlap flag, one cycle after the pixel
module hit_detector
    import game_pkg::*;
#(
    parameter int unsigned PLAYER_SIZE = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] player_x,
    input  logic [11:0] player_y,
    input  logic [11:0] obstacle_x,
    input  logic [11:0] obstacle_y,
    output logic        overlap
);

    logic        overlap_q, overlap_d;
    logic [12:0] px, py, ox, oy;

    // 13-bit operands so the far hitbox edge never wraps near 4095.
    assign px = {1'b0, player_x};
    assign py = {1'b0, player_y};
    assign ox = {1'b0, obstacle_x};
    assign oy = {1'b0, obstacle_y};

    assign overlap_d = ((|obstacle_x) || (|obstacle_y))
                    && (ox >= px) && (ox <= px + 13'(PLAYER_SIZE - 1))
                    && (oy >= py) && (oy <= py + 13'(PLAYER_SIZE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) overlap_q <= 1'b0;
        else     overlap_q <= overlap_d;
    end

    assign overlap = overlap_q;

endmodule

// File: rtl/obstacle_sequencer.sv
// obstacle_sequencer: round-robin obstacle launcher with collision, HP, score and game over.
//   clk, rst              : pixel clock, async active-high reset
//   start                 : begin a game from IDLE or OVER
//   player_x, player_y    : player hitbox top-left
//   obstacle_x, obstacle_y: OR of obstacle pixel buses, (0,0) = no pixel
//   obstacle_done         : OR of obstacle done flags
//   selected              : active obstacle code
//   play_selected         : high while a game runs
//   done_out              : one-cycle launch strobe to every obstacle
//   hp, hit, score        : remaining HP, accepted-hit pulse, cleared obstacles
//   game_over             : high in OVER
module obstacle_sequencer
    import game_pkg::*;
#(
    parameter int unsigned NUM_OBSTACLES = 4,
    parameter int unsigned START_HP      = 3,
    parameter int unsigned PLAYER_SIZE   = 20,
    parameter int unsigned INVULN_CYCLES = 32000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] player_x,
    input  logic [11:0] player_y,
    input  logic [11:0] obstacle_x,
    input  logic [11:0] obstacle_y,
    input  logic        obstacle_done,
    output logic [2:0]  selected,
    output logic        play_selected,
    output logic        done_out,
    output logic [2:0]  hp,
    output logic        hit,
    output logic [7:0]  score,
    output logic        game_over
);

    seq_state_e  state_q;
    logic [2:0]  code_q, sel_q, hp_q;
    logic [7:0]  score_q;
    logic [24:0] inv_q;
    logic        play_q, done_q, hit_q, over_q;
    logic        overlap, accept;
    logic [2:0]  code_d;
    logic [7:0]  score_d;

    hit_detector #(.PLAYER_SIZE(PLAYER_SIZE)) u_hit (
        .clk        (clk),
        .rst        (rst),
        .player_x   (player_x),
        .player_y   (player_y),
        .obstacle_x (obstacle_x),
        .obstacle_y (obstacle_y),
        .overlap    (overlap)
    );

    assign accept  = (state_q == S_RUN) && overlap && (inv_q == 25'd0);
    assign code_d  = next_code(code_q, 3'(NUM_OBSTACLES));
    assign score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            code_q  <= LASERS_CODE;
            sel_q   <= NO_OBSTACLE;
            play_q  <= 1'b0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            over_q  <= 1'b0;
            hp_q    <= 3'(START_HP);
            score_q <= 8'd0;
            inv_q   <= 25'd0;
        end else begin
            done_q <= 1'b0;
            hit_q  <= 1'b0;
            inv_q  <= (inv_q != 25'd0) ? inv_q - 25'd1 : 25'd0;
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state_q <= S_ARM;
                        code_q  <= LASERS_CODE;
                        sel_q   <= LASERS_CODE;
                        play_q  <= 1'b1;
                        done_q  <= 1'b1;
                        over_q  <= 1'b0;
                        hp_q    <= 3'(START_HP);
                        score_q <= 8'd0;
                    end
                end
                S_ARM: state_q <= S_RUN;
                S_RUN: begin
                    // A fatal hit wins over a simultaneous done: no score for that obstacle.
                    if (accept) begin
                        hit_q <= 1'b1;
                        hp_q  <= hp_q - 3'd1;
                        inv_q <= 25'(INVULN_CYCLES);
                    end
                    if (accept && hp_q == 3'd1) begin
                        state_q <= S_OVER;
                        play_q  <= 1'b0;
                        over_q  <= 1'b1;
                    end else if (obstacle_done) begin
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    state_q <= S_ARM;
                    score_q <= score_d;
                    code_q  <= code_d;
                    sel_q   <= code_d;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign selected      = sel_q;
    assign play_selected = play_q;
    assign done_out      = done_q;
    assign hp            = hp_q;
    assign hit           = hit_q;
    assign score         = score_q;
    assign game_over     = over_q;

endmodule
